hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_pkg.sv | 42 ++++
 rtl/muldiv_step.sv | 34 +++
 rtl/hilo_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op codes, FSM encoding and op classification for the HI/LO unit
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_acc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic op_is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              mode_div,
  input  logic [DATA_W-1:0] part_hi,
  input  logic [DATA_W-1:0] part_lo,
  input  logic [DATA_W-1:0] opnd,
  output logic [DATA_W-1:0] next_hi,
  output logic [DATA_W-1:0] next_lo
);

  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_trial;
  logic [DATA_W-1:0] div_diff;
  logic              div_fits;

  always_comb begin
    // Multiply: {hi,lo} holds {partial, remaining multiplier}; add then shift right.
    mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : '0);
    // Divide: {hi,lo} holds {remainder, dividend/quotient}; shift left then trial-subtract.
    div_trial = {part_hi, part_lo[DATA_W-1]};
    div_fits  = (div_trial >= {1'b0, opnd});
    div_diff  = div_trial[DATA_W-1:0] - opnd;
    if (mode_div) begin
      next_hi = div_fits ? div_diff : div_trial[DATA_W-1:0];
      next_lo = {part_lo[DATA_W-2:0], div_fits};
    end else begin
      next_hi = mul_sum[DATA_W:1];
      next_lo = {mul_sum[0], part_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO register pair
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, div_zero_q, div_zero_d;
  logic [DATA_W-1:0]   part_hi_q, part_hi_d, part_lo_q, part_lo_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [3:0]          op_q, op_d;
  logic                neg_q, neg_d, rem_neg_q, rem_neg_d;

  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic                in_signed;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quot_s, rem_s;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .mode_div (op_is_div(op_q)),
    .part_hi  (part_hi_q),
    .part_lo  (part_lo_q),
    .opnd     (opnd_q),
    .next_hi  (step_hi),
    .next_lo  (step_lo)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      part_hi_q  <= '0;
      part_lo_q  <= '0;
      opnd_q     <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      part_hi_q  <= part_hi_d;
      part_lo_q  <= part_lo_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

  always_comb begin
    in_signed = op_is_signed(op);
    a_abs     = (in_signed && a[DATA_W-1]) ? -a : a;
    b_abs     = (in_signed && b[DATA_W-1]) ? -b : b;
    // Magnitude iteration then sign fix-up; most-negative / -1 wraps back to most-negative.
    prod_s    = neg_q ? -{part_hi_q, part_lo_q} : {part_hi_q, part_lo_q};
    quot_s    = neg_q ? -part_lo_q : part_lo_q;
    rem_s     = rem_neg_q ? -part_hi_q : part_hi_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    part_hi_d  = part_hi_q;
    part_lo_d  = part_lo_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          if (op == OP_MTHI) begin
            hi_d   = a;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = a;
            done_d = 1'b1;
          end else if (op_is_div(op) && (b == '0)) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else if (op_is_mul(op) || op_is_div(op)) begin
            op_d      = op;
            cnt_d     = '0;
            part_hi_d = '0;
            neg_d     = in_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
            rem_neg_d = in_signed && a[DATA_W-1];
            part_lo_d = op_is_div(op) ? a_abs : b_abs;
            opnd_d    = op_is_div(op) ? b_abs : a_abs;
            state_d   = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        part_hi_d = step_hi;
        part_lo_d = step_lo;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (op_is_div(op_q)) begin
          hi_d = rem_s;
          lo_d = quot_s;
        end else if (op_is_acc(op_q)) begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        end else if (op_is_sub(op_q)) begin
          {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        end else begin
          {hi_d, lo_d} = prod_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush wins over everything, including a same-cycle FIX write.
    if (kill) begin
      state_d    = ST_IDLE;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drives one start cycle; returns at #1 after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  // Samples n cycles starting now, tallying busy/done/div_zero and hi/lo movement while busy.
  task automatic observe(input int n, output int busy_cnt, output int done_cnt,
                         output int zero_cnt, output int moved);
    logic [31:0] h0, l0;
    busy_cnt = 0;
    done_cnt = 0;
    zero_cnt = 0;
    moved    = 0;
    h0 = hi;
    l0 = lo;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge Clk);
        #1;
      end
      if (busy) begin
        busy_cnt++;
        if (hi !== h0 || lo !== l0) moved++;
      end
      if (done) done_cnt++;
      if (div_zero) zero_cnt++;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero", hi, lo, busy, done, div_zero);
    end
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_mult;
    int bc, dc, zc, mv;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (bc !== 33 || dc !== 1 || mv !== 0) begin
      failures++;
      $display("FAIL mult_timing: busy=%0d done=%0d moved=%0d required 33/1/0", bc, dc, mv);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      failures++;
      $display("FAIL mult_result: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
    end
    issue(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA || dc !== 1) begin
      failures++;
      $display("FAIL multu_result: hi=%h lo=%h done=%0d required 00000002 fffffffa 1", hi, lo, dc);
    end
  endtask

  task automatic test_div;
    int bc, dc, zc, mv;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || bc !== 33 || dc !== 1 || zc !== 0) begin
      failures++;
      $display("FAIL div_neg: lo=%h hi=%h busy=%0d done=%0d dz=%0d required fffffffd ffffffff 33 1 0", lo, hi, bc, dc, zc);
    end
    issue(OP_DIVU, 32'd7, 32'd2);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      failures++;
      $display("FAIL divu: lo=%h hi=%h required 3 1", lo, hi);
    end
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      failures++;
      $display("FAIL div_neg_divisor: lo=%h hi=%h required fffffffd 1", lo, hi);
    end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0 || dc !== 1) begin
      failures++;
      $display("FAIL div_overflow: lo=%h hi=%h done=%0d required 80000000 0 1", lo, hi, dc);
    end
  endtask

  task automatic test_div_zero;
    int bc, dc, zc, mv;
    issue(OP_MTHI, 32'h11, 32'h0);
    checks++;
    if (hi !== 32'h11 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h done=%b busy=%b required 11 1 0", hi, done, busy);
    end
    issue(OP_MTLO, 32'h22, 32'h0);
    checks++;
    if (lo !== 32'h22 || done !== 1'b1 || busy !== 1'b0 || hi !== 32'h11) begin
      failures++;
      $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b required 22 11 1 0", lo, hi, done, busy);
    end
    issue(OP_DIVU, 32'd7, 32'd0);
    checks++;
    if (done !== 1'b1 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_zero_flag: done=%b dz=%b required 1 1", done, div_zero);
    end
    observe(5, bc, dc, zc, mv);
    checks++;
    if (bc !== 0 || dc !== 1 || zc !== 1 || hi !== 32'h11 || lo !== 32'h22) begin
      failures++;
      $display("FAIL div_zero_after: busy=%0d done=%0d dz=%0d hi=%h lo=%h required 0 1 1 11 22", bc, dc, zc, hi, lo);
    end
  endtask

  task automatic test_madd_msub;
    int bc, dc, zc, mv;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    issue(OP_MADDU, 32'd1, 32'd1);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd0 || dc !== 1) begin
      failures++;
      $display("FAIL maddu: hi=%h lo=%h done=%0d required 1 0 1", hi, lo, dc);
    end
    issue(OP_MSUB, 32'd1, 32'd1);
    observe(40, bc, dc, zc, mv);
    checks++;
    if (hi !== 32'd0 || lo !== 32'hFFFFFFFF || mv !== 0) begin
      failures++;
      $display("FAIL msub: hi=%h lo=%h moved=%0d required 0 ffffffff 0", hi, lo, mv);
    end
  endtask

  task automatic test_kill;
    int bc, dc, zc, mv;
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    issue(OP_MULT, 32'd5, 32'd7);
    for (int k = 2; k <= 10; k++) begin
      @(posedge Clk);
      #1;
    end
    kill = 1'b1;
    @(posedge Clk);
    #1;
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== h0 || lo !== l0) begin
      failures++;
      $display("FAIL kill: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", busy, done, hi, lo, h0, l0);
    end
    observe(35, bc, dc, zc, mv);
    checks++;
    if (dc !== 0 || bc !== 0) begin
      failures++;
      $display("FAIL kill_no_done: done=%0d busy=%0d required 0 0", dc, bc);
    end
    issue(OP_MTHI, 32'h5, 32'h0);
    checks++;
    if (hi !== 32'h5) begin
      failures++;
      $display("FAIL mthi_after_kill: hi=%h required 5", hi);
    end
    kill = 1'b1;
    issue(OP_MTHI, 32'h77, 32'h0);
    kill = 1'b0;
    checks++;
    if (hi !== 32'h5 || done !== 1'b0) begin
      failures++;
      $display("FAIL kill_same_cycle: hi=%h done=%b required 5 0", hi, done);
    end
  endtask

  task automatic test_back_to_back;
    int dc;
    dc = 0;
    issue(OP_MULT, 32'd6, 32'd7);
    for (int i = 0; i < 45; i++) begin
      if (i == 3) begin
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h9;
      end
      if (i == 4) start = 1'b0;
      if (done) dc++;
      @(posedge Clk);
      #1;
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'd42 || dc !== 1) begin
      failures++;
      $display("FAIL start_while_busy: hi=%h lo=%h done=%0d required 0 2a 1", hi, lo, dc);
    end
    issue(OP_MULT, 32'd3, 32'd3);
    repeat (5) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b dz=%b required all zero", hi, lo, busy, done, div_zero);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dc++;
      @(posedge Clk);
      #1;
    end
    checks++;
    if (dc !== 0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_discards: activity=%0d lo=%h required 0 0", dc, lo);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst      = 1'b1;
    start    = 1'b0;
    op       = 4'd0;
    a        = 32'h0;
    b        = 32'h0;
    kill     = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_madd_msub();
    test_kill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
